tx_fir_shaper: RTL and testbench

Transmit-side pulse-shaping FIR. It is the counterpart of the adaptive receive equaliser and sits between the symbol mapper and the DAC interface. It accepts one sample per valid/ready handshake and filters it through a programmable NUM_TAPS-tap coefficient bank. The filter uses a single time-multiplexed multiply-accumulate, and it returns the rounded, saturated result on a valid/ready output port.

---
 rtl/tx_fir_shaper.sv | 150 +++++++++++++++
 tb/tb_tx_fir_shaper.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tx_fir_shaper.sv
`default_nettype none
// ============================================================================
// Module   : tx_fir_shaper
// Brief    : Transmit pulse-shaping FIR, one time-multiplexed MAC per tap.
// Revision : 1.0
// ============================================================================
module tx_fir_shaper #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    input  logic                          coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0]   coef_addr,
    input  logic [COEF_WIDTH-1:0]         coef_data,
    output logic                          busy
);

    localparam int c_PTR_W  = $clog2(NUM_TAPS);
    localparam int c_PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int c_ACC_W  = c_PROD_W + c_PTR_W;

    localparam logic [c_PTR_W:0]            c_TAPS = (c_PTR_W+1)'(NUM_TAPS);
    localparam logic [c_PTR_W-1:0]          c_LAST = c_PTR_W'(NUM_TAPS - 1);
    localparam logic signed [COEF_WIDTH-1:0] c_H0  = {1'b0, {(COEF_WIDTH-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0]   c_RND  =
        {{(c_ACC_W-COEF_WIDTH+1){1'b0}}, 1'b1, {(COEF_WIDTH-2){1'b0}}};
    localparam logic signed [c_ACC_W-1:0]   c_MAX  =
        {{(c_ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0]   c_MIN  =
        {{(c_ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic signed [DATA_WIDTH-1:0]    r_x [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]    r_h [NUM_TAPS];
    logic [c_PTR_W-1:0]              r_wr_ptr;
    logic [c_PTR_W-1:0]              r_k;
    logic signed [c_ACC_W-1:0]       r_acc;
    logic [DATA_WIDTH-1:0]           r_m_data;
    logic                            r_m_valid;

    logic [c_PTR_W:0]                w_rd_wide;
    logic [c_PTR_W-1:0]              w_rd_idx;
    logic signed [c_PROD_W-1:0]      w_prod;
    logic signed [c_ACC_W-1:0]       w_prod_ext;
    logic signed [c_ACC_W-1:0]       w_shift;
    logic [DATA_WIDTH-1:0]           w_sat;
    logic                            w_addr_ok;

    // Circular delay-line read index (wr_ptr - k) mod NUM_TAPS, valid for any tap count.
    always_comb begin
        w_rd_wide = '0;
        if (r_wr_ptr >= r_k)
            w_rd_wide = {1'b0, r_wr_ptr} - {1'b0, r_k};
        else
            w_rd_wide = {1'b0, r_wr_ptr} + c_TAPS - {1'b0, r_k};
        w_rd_idx = w_rd_wide[c_PTR_W-1:0];
    end

    always_comb begin
        w_prod     = r_x[w_rd_idx] * r_h[r_k];
        w_prod_ext = {{c_PTR_W{w_prod[c_PROD_W-1]}}, w_prod};
        w_shift    = (r_acc + c_RND) >>> (COEF_WIDTH - 1);
        if (w_shift > c_MAX)
            w_sat = c_MAX[DATA_WIDTH-1:0];
        else if (w_shift < c_MIN)
            w_sat = c_MIN[DATA_WIDTH-1:0];
        else
            w_sat = w_shift[DATA_WIDTH-1:0];
        w_addr_ok = ({1'b0, coef_addr} < c_TAPS);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (s_valid) w_state_next = S_MAC;
            S_MAC:   if (r_k == c_LAST) w_state_next = S_ROUND;
            S_ROUND: w_state_next = S_OUT;
            S_OUT:   if (m_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_x[i] <= '0;
                if (i == 0)
                    r_h[i] <= c_H0;
                else
                    r_h[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            // A write in the accept cycle lands before the MAC reads the bank.
            if (r_state == S_IDLE && coef_we && w_addr_ok)
                r_h[coef_addr] <= coef_data;
            case (r_state)
                S_IDLE: begin
                    if (s_valid) begin
                        r_x[r_wr_ptr] <= s_data;
                        r_acc         <= '0;
                        r_k           <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_k   <= r_k + 1'b1;
                end
                S_ROUND: begin
                    r_m_data  <= w_sat;
                    r_m_valid <= 1'b1;
                    r_wr_ptr  <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
                end
                S_OUT: begin
                    if (m_ready) r_m_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign s_ready = (r_state == S_IDLE);
    assign busy    = (r_state != S_IDLE);
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_tx_fir_shaper.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_fir_shaper
// Brief    : Directed plus randomized bench for tx_fir_shaper with a history-queue model.
// Revision : 1.0
// ============================================================================
module tb_tx_fir_shaper;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          busy;

    tx_fir_shaper #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(N)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int hist[$];
    int h_m[N];
    int last_mv  = -1;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Output = sum over the last N samples (newest first) times h, rounded and clamped.
    function automatic int model_out();
        longint acc = 0;
        for (int k = 0; k < hist.size(); k++)
            acc += longint'(hist[k]) * longint'(h_m[k]);
        acc = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    function automatic int model_push(input int d);
        hist.push_front(d);
        if (hist.size() > N) void'(hist.pop_back());
        return model_out();
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < N; k++) h_m[k] = 0;
        h_m[0] = 32767;
    endtask

    task automatic wcoef(input int a, input int v);
        coef_we = 1'b1; coef_addr = AW'(a); coef_data = CW'(v);
        @(posedge clk); #1;
        coef_we = 1'b0;
        h_m[a] = v;
    endtask

    task automatic xfer(input int d, input int hold, input bit we, input int wa,
                        input int wd, input bit chk_space);
        int g;
        int t0;
        int exp;
        g = 0;
        while (!s_ready && g < 200) begin @(posedge clk); #1; g++; end
        check("s_ready_wait", s_ready, 1);
        if (hold > 0) m_ready = 1'b0;
        s_data = DW'(d); s_valid = 1'b1;
        coef_we = we; coef_addr = AW'(wa); coef_data = CW'(wd);
        @(posedge clk); #1;
        t0 = cyc;
        s_valid = 1'b0; coef_we = 1'b0;
        if (we) h_m[wa] = wd;
        exp = model_push(d);
        g = 0;
        while (!m_valid && g < 200) begin @(posedge clk); #1; g++; end
        check("latency", cyc - t0, N + 1);
        check("m_data", $signed(m_data), exp);
        check("ready_valid_excl", s_ready, 0);
        check("busy_out", busy, 1);
        if (chk_space && last_mv >= 0) check("mvalid_spacing", cyc - last_mv, N + 3);
        last_mv = cyc;
        for (int i = 0; i < hold; i++) begin
            s_valid = (i == 3); s_data = 16'h1234;
            coef_we = (i == 5); coef_addr = '0; coef_data = '0;
            @(posedge clk); #1;
            check("bp_hold_valid", m_valid, 1);
            check("bp_hold_data", $signed(m_data), exp);
            check("bp_s_ready", s_ready, 0);
        end
        s_valid = 1'b0; coef_we = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        check("handshake_done", {m_valid, s_ready}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);

        xfer(1000, 0, 0, 0, 0, 0);
        xfer(-1000, 0, 0, 0, 0, 0);

        // Backpressure with stray s_valid and a coefficient write during busy.
        xfer(500, 10, 0, 0, 0, 0);
        xfer(-777, 0, 0, 0, 0, 0);

        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        model_reset();
        for (int k = 0; k < N; k++) wcoef(k, 100 * k);
        xfer(32767, 0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) xfer(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < N; k++) wcoef(k, 32767);
        for (int i = 0; i < 16; i++) xfer(32767, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) xfer(-32768, 0, 0, 0, 0, 0);

        for (int k = 0; k < N; k++) wcoef(k, 2048);
        last_mv = -1;
        for (int i = 0; i < 40; i++) xfer(1600, 0, 0, 0, 0, 1);

        // Reset while the MAC is at tap 5.
        s_data = DW'(1234); s_valid = 1'b1;
        @(posedge clk); #1 s_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("busy_in_mac", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        check("midrst_m_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_m_data", m_data, 0);
        xfer(1000, 0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int d;
            int wa;
            int wd;
            d  = int'($urandom_range(0, 65535)) - 32768;
            wa = int'($urandom_range(0, N - 1));
            wd = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 3) == 0) wcoef(int'($urandom_range(0, N - 1)),
                                                int'($urandom_range(0, 65535)) - 32768);
            xfer(d, int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), wa, wd, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
